// File: rtl/mem_arb_pkg.sv
// Shared state encoding, grant constants and sizing helper for the
// memory port arbiter of the multicycle CPU.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Grant encodings double as the IorD mux select.
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    // Width able to hold MEM_LATENCY-1, never narrower than one bit.
    function automatic int unsigned cntWidth(input int unsigned latency);
        return (latency <= 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// Loadable down-counter that flags when the memory read latency has elapsed.
// Parks at zero so the terminal flag stays asserted until the next load.
module wait_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_enable,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported memory between instruction fetch and load/store,
// round-robin on ties, with every output registered or decoded from state.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              IorD,
    output logic              busy
);

    localparam int unsigned      CNT_W    = cntWidth(MEM_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_rdData;
    logic              r_iorD;
    logic              r_lastLs;
    logic              w_grantValid;
    logic              w_grantLs;
    logic              w_latencyDone;

    wait_counter #(
        .WIDTH(CNT_W)
    ) u_waitCounter (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_grantValid),
        .i_loadValue(CNT_LOAD),
        .i_enable   (r_state == READ),
        .o_terminal (w_latencyDone)
    );

    // Requests are only looked at in IDLE; a tie goes to whoever lost last time.
    always_comb begin
        w_nextState  = r_state;
        w_grantValid = 1'b0;
        w_grantLs    = GNT_IF;
        case (r_state)
            IDLE: begin
                if (if_req && ls_req) begin
                    w_grantValid = 1'b1;
                    w_grantLs    = ~r_lastLs;
                end else if (if_req) begin
                    w_grantValid = 1'b1;
                    w_grantLs    = GNT_IF;
                end else if (ls_req) begin
                    w_grantValid = 1'b1;
                    w_grantLs    = GNT_LS;
                end
                if (w_grantValid) begin
                    w_nextState = (w_grantLs == GNT_LS && ls_we) ? WRITE : READ;
                end
            end
            READ: begin
                if (w_latencyDone) begin
                    w_nextState = RESP;
                end
            end
            WRITE:   w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_rdData   <= '0;
            r_iorD     <= GNT_IF;
            r_lastLs   <= 1'b1;
        end else begin
            r_state <= w_nextState;
            if (w_grantValid) begin
                r_iorD    <= w_grantLs;
                r_lastLs  <= w_grantLs;
                r_memAddr <= (w_grantLs == GNT_LS) ? ls_addr : if_addr;
                if (w_grantLs == GNT_LS && ls_we) begin
                    r_memWdata <= ls_wdata;
                end
            end
            if (r_state == READ && w_latencyDone) begin
                r_rdData <= mem_rdata;
            end
        end
    end

    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign rd_data   = r_rdData;
    assign IorD      = r_iorD;
    assign mem_wr    = (r_state == WRITE);
    assign busy      = (r_state != IDLE);
    assign if_done   = (r_state == RESP) && (r_iorD == GNT_IF);
    assign ls_done   = (r_state == RESP) && (r_iorD == GNT_LS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected completions,
// a negedge monitor pops and compares them as the arbiter reports done.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;

    logic        ifReq, lsReq, lsWe;
    logic [31:0] ifAddr, lsAddr, lsWdata;
    logic        ifDone, lsDone, memWr, iorD, busy;
    logic [31:0] rdData, memAddr, memWdata, memRdata;

    logic        bIfReq, bLsReq;
    logic [31:0] bIfAddr, bLsAddr, bLsWdata;
    logic        bIfDone, bLsDone, bMemWr, bIorD, bBusy;
    logic [31:0] bRdData, bMemAddr, bMemWdata, bMemRdata;

    typedef struct {
        logic        isLs;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          doneCycle;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] modelRd = 32'h0;
    logic        wrSeen = 1'b0;
    logic [31:0] pipeA;
    logic [31:0] pipeB [3];

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    mem_port_arbiter #(.MEM_LATENCY(2), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .if_req(ifReq), .if_addr(ifAddr), .if_done(ifDone),
        .ls_req(lsReq), .ls_we(lsWe), .ls_addr(lsAddr), .ls_wdata(lsWdata), .ls_done(lsDone),
        .rd_data(rdData), .mem_addr(memAddr), .mem_wr(memWr), .mem_wdata(memWdata),
        .mem_rdata(memRdata), .IorD(iorD), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LATENCY(4), .ADDR_W(32), .DATA_W(32)) dutLat4 (
        .clock(clock), .reset(reset),
        .if_req(bIfReq), .if_addr(bIfAddr), .if_done(bIfDone),
        .ls_req(bLsReq), .ls_we(1'b0), .ls_addr(bLsAddr), .ls_wdata(bLsWdata), .ls_done(bLsDone),
        .rd_data(bRdData), .mem_addr(bMemAddr), .mem_wr(bMemWr), .mem_wdata(bMemWdata),
        .mem_rdata(bMemRdata), .IorD(bIorD), .busy(bBusy)
    );

    // Memory contents; 0x04 holds the lw instruction used in the fetch test.
    function automatic logic [31:0] memInit(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C22_0000;
        return {a[15:0], 16'h0} ^ 32'h1234_5678 ^ a;
    endfunction

    // Synchronous memories: data for an address appears LATENCY-1 edges later.
    always @(posedge clock) begin
        pipeA    <= memInit(memAddr);
        pipeB[0] <= memInit(bMemAddr);
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end
    assign memRdata  = pipeA;
    assign bMemRdata = pipeB[2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic pushExp(input logic isLs, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int doneCycle);
        exp_t e;
        e.isLs      = isLs;
        e.we        = we;
        e.addr      = addr;
        e.wdata     = wdata;
        e.rdata     = we ? modelRd : memInit(addr);
        e.doneCycle = doneCycle;
        modelRd     = e.rdata;
        expQ.push_back(e);
    endtask

    // Raises one request, holds it until its done pulse, then drops it.
    task automatic applyStimulus(input logic isLs, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        if (isLs) begin
            lsWe = we; lsAddr = addr; lsWdata = wdata; lsReq = 1'b1;
        end else begin
            ifAddr = addr; ifReq = 1'b1;
        end
        while (!seen && n < 40) begin
            @(negedge clock);
            n++;
            seen = isLs ? lsDone : ifDone;
        end
        if (isLs) lsReq = 1'b0;
        else      ifReq = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: no done for addr 0x%08h after %0d cycles", addr, n);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rstRdData",   rdData,          32'h0);
        checkOutput("rstMemAddr",  memAddr,         32'h0);
        checkOutput("rstMemWdata", memWdata,        32'h0);
        checkOutput("rstMemWr",    32'(memWr),      32'h0);
        checkOutput("rstIorD",     32'(iorD),       32'h0);
        checkOutput("rstIfDone",   32'(ifDone),     32'h0);
        checkOutput("rstLsDone",   32'(lsDone),     32'h0);
        checkOutput("rstBusy",     32'(busy),       32'h0);
    endtask

    // Monitor: address hold while busy, write strobe timing, done scoreboard.
    exp_t front;
    always @(negedge clock) begin
        if (busy && expQ.size() != 0) begin
            checkOutput("addrHold", memAddr, expQ[0].addr);
            checkOutput("iorDHold", 32'(iorD), 32'(expQ[0].isLs));
        end
        if (memWr) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 32'(memWr), 32'h0);
            end else begin
                checkOutput("wrIsStore", 32'(expQ[0].isLs & expQ[0].we), 32'h1);
                checkOutput("wrAddr",    memAddr,  expQ[0].addr);
                checkOutput("wrData",    memWdata, expQ[0].wdata);
                checkOutput("wrCycle",   32'(cycle), 32'(expQ[0].doneCycle - 1));
                wrSeen = 1'b1;
            end
        end
        if (ifDone || lsDone) begin
            checkOutput("doneExclusive", 32'(ifDone & lsDone), 32'h0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'(ifDone | lsDone), 32'h0);
            end else begin
                front = expQ.pop_front();
                checkOutput("doneWho",   32'(lsDone),  32'(front.isLs));
                checkOutput("doneCycle", 32'(cycle),   32'(front.doneCycle));
                checkOutput("rdData",    rdData,       front.rdata);
                checkOutput("doneAddr",  memAddr,      front.addr);
                checkOutput("doneIorD",  32'(iorD),    32'(front.isLs));
                checkOutput("wrCount",   32'(wrSeen),  32'(front.we));
                wrSeen = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        ifReq = 1'b0; lsReq = 1'b0; lsWe = 1'b0;
        ifAddr = '0; lsAddr = '0; lsWdata = '0;
        bIfReq = 1'b0; bLsReq = 1'b0;
        bIfAddr = '0; bLsAddr = '0; bLsWdata = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checkResetState();
        reset = 1'b1;
        @(negedge clock);

        // Fetch from 0x04, read data returned in cycle 3.
        pushExp(1'b0, 1'b0, 32'h4, 32'h0, cycle + 3);
        applyStimulus(1'b0, 1'b0, 32'h4, 32'h0);
        repeat (2) @(negedge clock);

        // Store 0xDEADBEEF to 0x100; rd_data keeps the fetched word.
        pushExp(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, cycle + 2);
        applyStimulus(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        repeat (2) @(negedge clock);

        // Load raised while a fetch is in READ waits for IDLE.
        base = cycle;
        pushExp(1'b0, 1'b0, 32'h8,  32'h0, base + 3);
        pushExp(1'b1, 1'b0, 32'h40, 32'h0, base + 7);
        fork
            applyStimulus(1'b0, 1'b0, 32'h8, 32'h0);
            begin
                @(negedge clock);
                applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
            end
        join
        repeat (2) @(negedge clock);

        // Reset during cycle 2 of a fetch: no done, everything back to reset values.
        ifAddr = 32'hC;
        ifReq  = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ifReq = 1'b0;
        @(negedge clock);
        checkResetState();
        reset   = 1'b1;
        modelRd = 32'h0;
        @(negedge clock);

        // Both requesters continuously busy: IF, LS, IF, LS from a fresh reset.
        base = cycle;
        pushExp(1'b0, 1'b0, 32'h10, 32'h0,         base + 3);
        pushExp(1'b1, 1'b0, 32'h20, 32'h0,         base + 7);
        pushExp(1'b0, 1'b0, 32'h14, 32'h0,         base + 11);
        pushExp(1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, base + 14);
        fork
            begin
                applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
                applyStimulus(1'b0, 1'b0, 32'h14, 32'h0);
            end
            begin
                applyStimulus(1'b1, 1'b0, 32'h20, 32'h0);
                applyStimulus(1'b1, 1'b1, 32'h24, 32'hCAFE_F00D);
            end
        join
        repeat (2) @(negedge clock);

        // Four-cycle latency instance: load from 0x200, done in cycle 5.
        bLsAddr = 32'h200;
        bLsReq  = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            if (k <= 4) begin
                checkOutput("lat4AddrHold", bMemAddr,      32'h200);
                checkOutput("lat4NoDone",   32'(bLsDone),  32'h0);
            end else begin
                checkOutput("lat4Done",     32'(bLsDone),  32'h1);
                checkOutput("lat4IfDone",   32'(bIfDone),  32'h0);
                checkOutput("lat4RdData",   bRdData,       memInit(32'h200));
                checkOutput("lat4IorD",     32'(bIorD),    32'h1);
            end
        end
        bLsReq = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("lat4Idle", 32'(bBusy), 32'h0);

        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
